// File: rtl/board_checker.sv
// board_checker: validates a 9x9 sudoku board held in an external memory.
// Three passes (rows, columns, boxes) read one cell per cycle. The scan stops
// at the first empty, out-of-range or duplicated cell and reports its address.
module board_checker (
    input  logic       clka,
    input  logic       restart_n,
    input  logic       start,
    output logic [6:0] rd_addr,
    input  logic [3:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       solved,
    output logic [6:0] fail_addr,
    output logic [1:0] fail_code
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        FINISH = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PASS_ROW = 2'd0,
        PASS_COL = 2'd1,
        PASS_BOX = 2'd2
    } pass_t;

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_EMPTY   = 2'b01;
    localparam logic [1:0] CODE_INVALID = 2'b10;
    localparam logic [1:0] CODE_DUP     = 2'b11;

    state_t     state;
    pass_t      pass_sel;
    logic [3:0] grp;
    logic [3:0] idx;
    logic [8:0] seen;

    logic [3:0] row;
    logic [3:0] col;
    logic       cell_fail;
    logic [1:0] cell_code;
    logic [8:0] digit_bit;

    // Integer divide-by-3 of a group/index value in 0..8.
    function automatic logic [3:0] div3(input logic [3:0] v);
        if (v >= 4'd6)      return 4'd2;
        else if (v >= 4'd3) return 4'd1;
        else                return 4'd0;
    endfunction

    // Remainder modulo 3 of a group/index value in 0..8.
    function automatic logic [3:0] mod3(input logic [3:0] v);
        return v - 4'd3 * div3(v);
    endfunction

    // Map (pass, group, index) to the board coordinate being read this cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        row = 4'd0;
        col = 4'd0;
        unique case (pass_sel)
            PASS_ROW: begin
                row = grp;
                col = idx;
            end
            PASS_COL: begin
                row = idx;
                col = grp;
            end
            PASS_BOX: begin
                row = 4'd3 * div3(grp) + div3(idx);
                col = 4'd3 * mod3(grp) + mod3(idx);
            end
            default: begin
                row = 4'd0;
                col = 4'd0;
            end
        endcase
    end

    // The board address is only driven while scanning; otherwise it parks at 0.
    always_comb begin
        rd_addr = 7'd0;
        if (state == SCAN) begin
            rd_addr = {3'd0, row} * 7'd9 + {3'd0, col};
        end
    end

    // Classify the cell currently on rd_data, in priority order.
    always_comb begin
        digit_bit = 9'd0;
        cell_fail = 1'b0;
        cell_code = CODE_NONE;
        if (rd_data >= 4'd1 && rd_data <= 4'd9) begin
            digit_bit = 9'd1 << (rd_data - 4'd1);
        end
        if (rd_data == 4'd0) begin
            cell_fail = 1'b1;
            cell_code = CODE_EMPTY;
        end else if (rd_data > 4'd9) begin
            cell_fail = 1'b1;
            cell_code = CODE_INVALID;
        end else if ((seen & digit_bit) != 9'd0) begin
            cell_fail = 1'b1;
            cell_code = CODE_DUP;
        end
    end

    // Control FSM: counters, seen mask and all registered result outputs.
    always_ff @(posedge clka) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!restart_n) begin
            state     <= IDLE;
            pass_sel  <= PASS_ROW;
            grp       <= 4'd0;
            idx       <= 4'd0;
            seen      <= 9'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            solved    <= 1'b0;
            fail_addr <= 7'd0;
            fail_code <= CODE_NONE;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SCAN;
                        busy      <= 1'b1;
                        pass_sel  <= PASS_ROW;
                        grp       <= 4'd0;
                        idx       <= 4'd0;
                        seen      <= 9'd0;
                        solved    <= 1'b0;
                        fail_addr <= 7'd0;
                        fail_code <= CODE_NONE;
                    end
                end

                SCAN: begin
                    if (cell_fail) begin
                        // First failure freezes the scan; no further reads.
                        state     <= FINISH;
                        done      <= 1'b1;
                        solved    <= 1'b0;
                        fail_addr <= rd_addr;
                        fail_code <= cell_code;
                    end else if (idx == 4'd8) begin
                        // Group complete: fresh mask for the next group.
                        seen <= 9'd0;
                        idx  <= 4'd0;
                        if (grp == 4'd8) begin
                            grp <= 4'd0;
                            if (pass_sel == PASS_BOX) begin
                                state     <= FINISH;
                                done      <= 1'b1;
                                solved    <= 1'b1;
                                fail_addr <= 7'd0;
                                fail_code <= CODE_NONE;
                            end else begin
                                pass_sel <= pass_t'(pass_sel + 2'd1);
                            end
                        end else begin
                            grp <= grp + 4'd1;
                        end
                    end else begin
                        seen <= seen | digit_bit;
                        idx  <= idx + 4'd1;
                    end
                end

                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_checker.sv
// Self-checking bench for board_checker: directed boards plus randomized
// boards, all compared against a loop-based sudoku reference model.
module tb_board_checker;

    logic       clka = 1'b0;
    logic       restart_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] rd_addr;
    logic [3:0] rd_data;
    logic       busy;
    logic       done;
    logic       solved;
    logic [6:0] fail_addr;
    logic [1:0] fail_code;

    logic [3:0] board [0:80];
    int errors = 0;
    int checks = 0;

    board_checker dut (
        .clka      (clka),
        .restart_n (restart_n),
        .start     (start),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .solved    (solved),
        .fail_addr (fail_addr),
        .fail_code (fail_code)
    );

    always #5 clka = ~clka;

    // Combinational board memory.
    assign rd_data = (rd_addr < 7'd81) ? board[rd_addr] : 4'd0;

    task automatic check(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Reference: walk rows, columns, boxes as a sudoku solver would and stop
    // at the first offending cell. exp_cycle is the cycle (after the start
    // edge) in which done is expected.
    task automatic model(output int exp_solved, output int exp_addr,
                         output int exp_code, output int exp_cycle,
                         output int addr_q[$]);
        int n;
        bit found;
        n = 0;
        found = 0;
        exp_solved = 1;
        exp_addr = 0;
        exp_code = 0;
        addr_q = {};
        for (int p = 0; p < 3 && !found; p++) begin
            for (int g = 0; g < 9 && !found; g++) begin
                bit seen_digit [1:9];
                for (int d = 1; d <= 9; d++) seen_digit[d] = 0;
                for (int i = 0; i < 9 && !found; i++) begin
                    int r, c, a, v;
                    if (p == 0) begin r = g; c = i; end
                    else if (p == 1) begin r = i; c = g; end
                    else begin r = (g / 3) * 3 + i / 3; c = (g % 3) * 3 + i % 3; end
                    a = r * 9 + c;
                    v = int'(board[a]);
                    n++;
                    addr_q.push_back(a);
                    if (v == 0) begin found = 1; exp_code = 1; end
                    else if (v > 9) begin found = 1; exp_code = 2; end
                    else if (seen_digit[v]) begin found = 1; exp_code = 3; end
                    else seen_digit[v] = 1;
                    if (found) begin
                        exp_solved = 0;
                        exp_addr = a;
                    end
                end
            end
        end
        exp_cycle = n + 1;
    endtask

    task automatic load_canonical();
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                board[r * 9 + c] = 4'(((3 * r + r / 3 + c) % 9) + 1);
    endtask

    // Issue one start and observe up to 300 cycles. extra_start / rst_cycle
    // (or -1) inject a second start or a reset at that cycle number.
    task automatic run(input string tag, input int extra_start, input int rst_cycle);
        int es, ea, ec, ecyc;
        int addr_q[$];
        int done_cyc, done_cnt, busy_bad, addr_bad, last_busy;
        model(es, ea, ec, ecyc, addr_q);
        last_busy = (rst_cycle < 0) ? ecyc : rst_cycle;
        done_cyc = -1;
        done_cnt = 0;
        busy_bad = 0;
        addr_bad = 0;
        @(negedge clka);
        start = 1'b1;
        @(posedge clka);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = k;
                    check({tag, ".solved"}, int'(solved), es);
                    check({tag, ".fail_addr"}, int'(fail_addr), ea);
                    check({tag, ".fail_code"}, int'(fail_code), ec);
                    check({tag, ".rd_addr_finish"}, int'(rd_addr), 0);
                end
            end
            if (busy !== (k <= last_busy)) busy_bad++;
            if (k < ecyc && k <= last_busy && rd_addr !== 7'(addr_q[k - 1])) addr_bad++;
            if (rst_cycle > 0 && k == rst_cycle + 1) begin
                check({tag, ".rst_solved"}, int'(solved), 0);
                check({tag, ".rst_rd_addr"}, int'(rd_addr), 0);
                check({tag, ".rst_fail_code"}, int'(fail_code), 0);
            end
            start = (k == extra_start);
            restart_n = !(k == rst_cycle);
            @(posedge clka);
            #1;
        end
        start = 1'b0;
        restart_n = 1'b1;
        check({tag, ".busy_profile"}, busy_bad, 0);
        check({tag, ".addr_sequence"}, addr_bad, 0);
        if (rst_cycle < 0) begin
            check({tag, ".done_cycle"}, done_cyc, ecyc);
            check({tag, ".done_count"}, done_cnt, 1);
            check({tag, ".solved_held"}, int'(solved), es);
            check({tag, ".fail_addr_held"}, int'(fail_addr), ea);
        end else begin
            check({tag, ".done_count"}, done_cnt, 0);
        end
    endtask

    initial begin
        int mode;
        load_canonical();

        // Reset state.
        restart_n = 1'b0;
        repeat (3) @(posedge clka);
        #1;
        check("reset.busy", int'(busy), 0);
        check("reset.done", int'(done), 0);
        check("reset.solved", int'(solved), 0);
        check("reset.rd_addr", int'(rd_addr), 0);
        check("reset.fail_addr", int'(fail_addr), 0);
        check("reset.fail_code", int'(fail_code), 0);

        // Reset wins over start on the same edge.
        @(negedge clka);
        start = 1'b1;
        @(posedge clka);
        #1;
        start = 1'b0;
        check("rst_vs_start.busy", int'(busy), 0);
        restart_n = 1'b1;

        // Canonical solved board.
        run("canonical", -1, -1);

        // Empty centre cell.
        load_canonical();
        board[40] = 4'd0;
        run("empty40", -1, -1);

        // Invalid last cell.
        load_canonical();
        board[80] = 4'd10;
        run("invalid80", -1, -1);

        // Swap cells 0 and 1: rows fine, column 0 duplicates.
        load_canonical();
        board[0] = 4'd2;
        board[1] = 4'd1;
        run("swap01", -1, -1);

        // Latin square: only boxes fail.
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                board[r * 9 + c] = 4'(((r + c) % 9) + 1);
        run("latin", -1, -1);

        // Second start mid-scan is ignored.
        load_canonical();
        run("restart_ignored", 50, -1);

        // Reset mid-scan aborts with no done.
        run("abort100", -1, 100);

        // Randomized boards.
        for (int t = 0; t < 20; t++) begin
            load_canonical();
            mode = int'($urandom_range(0, 3));
            if (mode == 0) begin
                int perm [1:9];
                for (int d = 1; d <= 9; d++) perm[d] = d;
                for (int d = 9; d > 1; d--) begin
                    int j, tmp;
                    j = int'($urandom_range(1, d));
                    tmp = perm[d]; perm[d] = perm[j]; perm[j] = tmp;
                end
                for (int a = 0; a < 81; a++) board[a] = 4'(perm[int'(board[a])]);
            end else if (mode == 1) begin
                board[$urandom_range(0, 80)] = 4'($urandom_range(0, 15));
            end else if (mode == 2) begin
                int a0, a1;
                logic [3:0] tmp;
                a0 = int'($urandom_range(0, 80));
                a1 = int'($urandom_range(0, 80));
                tmp = board[a0]; board[a0] = board[a1]; board[a1] = tmp;
            end else begin
                for (int a = 0; a < 81; a++) board[a] = 4'($urandom_range(1, 9));
            end
            run($sformatf("rand%0d_m%0d", t, mode), -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
